// File: rtl/result_bcd_conv_pkg.sv
// result_bcd_conv_pkg: shared FSM state type and default sizing for the BCD result converter.
package result_bcd_conv_pkg;
   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_SHIFT = 2'd1,
      S_DONE  = 2'd2
   } conv_state_t;
   localparam int BCD_W     = 4;
   localparam int WIDTH_32  = 32;
   localparam int DIGITS_32 = 10;
   localparam int CNTW_32   = 4;
endpackage

// File: rtl/bcd_add3.sv
// bcd_add3: double-dabble digit correction, adds 3 when the digit is 5 or more.
module bcd_add3 (
   input  logic [3:0] din,
   output logic [3:0] dout
);
   always_comb dout = (din >= 4'd5) ? din + 4'd3 : din;
endmodule

// File: rtl/result_bcd_conv.sv
// result_bcd_conv: sequential double-dabble converter, sign/magnitude result to packed BCD digits.
module result_bcd_conv
   import result_bcd_conv_pkg::*;
#(
   parameter int WIDTH  = WIDTH_32,
   parameter int DIGITS = DIGITS_32,
   parameter int CNTW   = CNTW_32
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      conv_start,
   input  logic [WIDTH-1:0]          conv_mag,
   input  logic                      conv_sign,
   input  logic                      conv_invld,
   output logic                      conv_busy,
   output logic                      conv_done,
   output logic [BCD_W*DIGITS-1:0]   bcd_digits,
   output logic                      bcd_sign,
   output logic [CNTW-1:0]           bcd_ndigits,
   output logic                      bcd_err
);
   localparam int BW = BCD_W * DIGITS;
   localparam int CW = $clog2(WIDTH);
   conv_state_t      state;
   logic [WIDTH-1:0] bin_sr;
   logic [BW-1:0]    bcd_sr;
   logic [BW-1:0]    bcd_adj;
   logic [BW-1:0]    bcd_nxt;
   logic [CW-1:0]    bit_cnt;
   logic             sign_r;
   logic             nz_r;
   logic [CNTW-1:0]  nd_nxt;
   genvar i;
   generate
      for (i = 0; i < DIGITS; i++) begin : g_add3
         bcd_add3 u_add3 (
            .din  (bcd_sr[BCD_W*i +: BCD_W]),
            .dout (bcd_adj[BCD_W*i +: BCD_W])
         );
      end
   endgenerate
   assign bcd_nxt   = {bcd_adj[BW-2:0], bin_sr[WIDTH-1]};
   assign conv_busy = state != S_IDLE;
   // Highest nonzero digit wins; an all-zero value still shows one digit.
   always_comb begin
      nd_nxt = CNTW'(1);
      for (int k = 0; k < DIGITS; k++)
         if (bcd_nxt[BCD_W*k +: BCD_W] != '0) nd_nxt = CNTW'(k + 1);
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= S_IDLE;
         bin_sr      <= '0;
         bcd_sr      <= '0;
         bit_cnt     <= '0;
         sign_r      <= 1'b0;
         nz_r        <= 1'b0;
         conv_done   <= 1'b0;
         bcd_digits  <= '0;
         bcd_sign    <= 1'b0;
         bcd_ndigits <= CNTW'(1);
         bcd_err     <= 1'b0;
      end else begin
         conv_done <= 1'b0;
         case (state)
            S_IDLE: if (conv_start) begin
               if (conv_invld) begin
                  state       <= S_DONE;
                  conv_done   <= 1'b1;
                  bcd_digits  <= '0;
                  bcd_sign    <= 1'b0;
                  bcd_ndigits <= CNTW'(1);
                  bcd_err     <= 1'b1;
               end else begin
                  state   <= S_SHIFT;
                  bin_sr  <= conv_mag;
                  sign_r  <= conv_sign;
                  nz_r    <= |conv_mag;
                  bcd_sr  <= '0;
                  bit_cnt <= '0;
               end
            end
            S_SHIFT: begin
               bcd_sr  <= bcd_nxt;
               bin_sr  <= {bin_sr[WIDTH-2:0], 1'b0};
               bit_cnt <= bit_cnt + 1'b1;
               if (bit_cnt == CW'(WIDTH - 1)) begin
                  state       <= S_DONE;
                  conv_done   <= 1'b1;
                  bcd_digits  <= bcd_nxt;
                  bcd_sign    <= sign_r & nz_r;
                  bcd_ndigits <= nd_nxt;
                  bcd_err     <= 1'b0;
               end
            end
            S_DONE:  state <= S_IDLE;
            default: state <= S_IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_result_bcd_conv.sv
// tb_result_bcd_conv: directed checks of the BCD converter with hand-computed expected values.
module tb_result_bcd_conv;
   logic        clk = 0;
   logic        rst = 1;
   logic        conv_start = 0;
   logic [31:0] conv_mag = 0;
   logic        conv_sign = 0;
   logic        conv_invld = 0;
   logic        conv_busy;
   logic        conv_done;
   logic [39:0] bcd_digits;
   logic        bcd_sign;
   logic [3:0]  bcd_ndigits;
   logic        bcd_err;
   int n_cmp = 0;
   int n_err = 0;
   int lat;

   result_bcd_conv dut (
      .clk         (clk),
      .rst         (rst),
      .conv_start  (conv_start),
      .conv_mag    (conv_mag),
      .conv_sign   (conv_sign),
      .conv_invld  (conv_invld),
      .conv_busy   (conv_busy),
      .conv_done   (conv_done),
      .bcd_digits  (bcd_digits),
      .bcd_sign    (bcd_sign),
      .bcd_ndigits (bcd_ndigits),
      .bcd_err     (bcd_err)
   );

   always #5 clk = ~clk;

   // Pulses start for one cycle and counts cycles until conv_done; -1 on timeout.
   task automatic do_conv(input logic [31:0] mag, input logic sg, input logic inv, output int l);
      @(negedge clk);
      conv_start = 1; conv_mag = mag; conv_sign = sg; conv_invld = inv;
      l = -1;
      for (int c = 1; c <= 100; c++) begin
         @(negedge clk);
         conv_start = 0; conv_invld = 0;
         if (conv_done) begin l = c; break; end
      end
   endtask

   task automatic test_reset;
      rst = 1;
      repeat (3) @(negedge clk);
      rst = 0;
      @(negedge clk);
      n_cmp++; if (conv_busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got %b want 0", conv_busy); end
      n_cmp++; if (conv_done !== 1'b0) begin n_err++; $display("FAIL reset_done got %b want 0", conv_done); end
      n_cmp++; if (bcd_digits !== 40'h0) begin n_err++; $display("FAIL reset_digits got %h want 0", bcd_digits); end
      n_cmp++; if (bcd_ndigits !== 4'd1) begin n_err++; $display("FAIL reset_ndigits got %0d want 1", bcd_ndigits); end
      n_cmp++; if ({bcd_sign, bcd_err} !== 2'b00) begin n_err++; $display("FAIL reset_sign_err got %b want 00", {bcd_sign, bcd_err}); end
   endtask

   task automatic test_zero;
      do_conv(32'd0, 1'b0, 1'b0, lat);
      n_cmp++; if (lat !== 33) begin n_err++; $display("FAIL zero_latency got %0d want 33", lat); end
      n_cmp++; if (bcd_digits !== 40'h0) begin n_err++; $display("FAIL zero_digits got %h want 0", bcd_digits); end
      n_cmp++; if (bcd_ndigits !== 4'd1) begin n_err++; $display("FAIL zero_ndigits got %0d want 1", bcd_ndigits); end
      n_cmp++; if ({bcd_sign, bcd_err} !== 2'b00) begin n_err++; $display("FAIL zero_sign_err got %b want 00", {bcd_sign, bcd_err}); end
      @(negedge clk);
      n_cmp++; if ({conv_done, conv_busy} !== 2'b00) begin n_err++; $display("FAIL zero_after got done/busy %b want 00", {conv_done, conv_busy}); end
   endtask

   task automatic test_max;
      do_conv(32'hFFFF_FFFF, 1'b0, 1'b0, lat);
      n_cmp++; if (bcd_digits !== 40'h42_9496_7295) begin n_err++; $display("FAIL max_digits got %h want 4294967295", bcd_digits); end
      n_cmp++; if (bcd_ndigits !== 4'd10) begin n_err++; $display("FAIL max_ndigits got %0d want 10", bcd_ndigits); end
      n_cmp++; if (bcd_sign !== 1'b0) begin n_err++; $display("FAIL max_sign got %b want 0", bcd_sign); end
   endtask

   task automatic test_sign;
      do_conv(32'd1234, 1'b1, 1'b0, lat);
      n_cmp++; if (bcd_digits !== 40'h00_0000_1234) begin n_err++; $display("FAIL neg_digits got %h want 0000001234", bcd_digits); end
      n_cmp++; if (bcd_ndigits !== 4'd4) begin n_err++; $display("FAIL neg_ndigits got %0d want 4", bcd_ndigits); end
      n_cmp++; if (bcd_sign !== 1'b1) begin n_err++; $display("FAIL neg_sign got %b want 1", bcd_sign); end
      do_conv(32'd0, 1'b1, 1'b0, lat);
      n_cmp++; if (bcd_sign !== 1'b0) begin n_err++; $display("FAIL negzero_sign got %b want 0", bcd_sign); end
      n_cmp++; if (bcd_ndigits !== 4'd1) begin n_err++; $display("FAIL negzero_ndigits got %0d want 1", bcd_ndigits); end
   endtask

   task automatic test_invalid;
      do_conv(32'd77, 1'b1, 1'b1, lat);
      n_cmp++; if (lat !== 1) begin n_err++; $display("FAIL inv_latency got %0d want 1", lat); end
      n_cmp++; if (bcd_err !== 1'b1) begin n_err++; $display("FAIL inv_err got %b want 1", bcd_err); end
      n_cmp++; if (bcd_digits !== 40'h0) begin n_err++; $display("FAIL inv_digits got %h want 0", bcd_digits); end
      n_cmp++; if (bcd_sign !== 1'b0) begin n_err++; $display("FAIL inv_sign got %b want 0", bcd_sign); end
      n_cmp++; if (bcd_ndigits !== 4'd1) begin n_err++; $display("FAIL inv_ndigits got %0d want 1", bcd_ndigits); end
      @(negedge clk);
      n_cmp++; if (conv_done !== 1'b0) begin n_err++; $display("FAIL inv_pulse got done %b want 0", conv_done); end
   endtask

   task automatic test_back_to_back;
      @(negedge clk);
      conv_start = 1; conv_mag = 32'd42; conv_sign = 0;
      for (int c = 1; c <= 33; c++) begin
         @(negedge clk);
         conv_start = 0;
         if (c < 33 && conv_done) begin n_cmp++; n_err++; $display("FAIL b2b_early_done at cycle %0d want 33", c); end
         if (c == 5) begin conv_start = 1; conv_mag = 32'd9; end
         if (c == 33) begin
            n_cmp++; if (conv_done !== 1'b1) begin n_err++; $display("FAIL b2b_done got %b want 1 at cycle 33", conv_done); end
            n_cmp++; if (bcd_digits !== 40'h42) begin n_err++; $display("FAIL b2b_digits got %h want 42", bcd_digits); end
            conv_start = 1; conv_mag = 32'd8;
         end
      end
      @(negedge clk);
      n_cmp++; if ({conv_busy, conv_done} !== 2'b00) begin n_err++; $display("FAIL b2b_ignored got busy/done %b want 00", {conv_busy, conv_done}); end
      n_cmp++; if (bcd_digits !== 40'h42) begin n_err++; $display("FAIL b2b_hold got %h want 42", bcd_digits); end
      conv_start = 1; conv_mag = 32'd5;
      lat = -1;
      for (int c = 1; c <= 100; c++) begin
         @(negedge clk);
         conv_start = 0;
         if (conv_done) begin lat = c; break; end
      end
      n_cmp++; if (lat !== 33) begin n_err++; $display("FAIL b2b_accept_latency got %0d want 33", lat); end
      n_cmp++; if (bcd_digits !== 40'h5) begin n_err++; $display("FAIL b2b_accept_digits got %h want 5", bcd_digits); end
   endtask

   task automatic test_reset_abort;
      int seen = 0;
      @(negedge clk);
      conv_start = 1; conv_mag = 32'd500;
      for (int c = 1; c <= 10; c++) begin
         @(negedge clk);
         conv_start = 0;
      end
      rst = 1;
      @(negedge clk);
      rst = 0;
      n_cmp++; if (conv_busy !== 1'b0) begin n_err++; $display("FAIL abort_busy got %b want 0", conv_busy); end
      n_cmp++; if (bcd_digits !== 40'h0) begin n_err++; $display("FAIL abort_digits got %h want 0", bcd_digits); end
      n_cmp++; if (bcd_ndigits !== 4'd1) begin n_err++; $display("FAIL abort_ndigits got %0d want 1", bcd_ndigits); end
      for (int c = 0; c < 40; c++) begin
         @(negedge clk);
         if (conv_done) seen++;
      end
      n_cmp++; if (seen !== 0) begin n_err++; $display("FAIL abort_no_done got %0d pulses want 0", seen); end
      do_conv(32'd99, 1'b0, 1'b0, lat);
      n_cmp++; if (bcd_digits !== 40'h99) begin n_err++; $display("FAIL abort_next_digits got %h want 99", bcd_digits); end
      n_cmp++; if (bcd_ndigits !== 4'd2) begin n_err++; $display("FAIL abort_next_ndigits got %0d want 2", bcd_ndigits); end
   endtask

   initial begin
      test_reset;
      test_zero;
      test_max;
      test_sign;
      test_invalid;
      test_back_to_back;
      test_reset_abort;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
